// File: rtl/mux_rr_reg_if.sv
// mux_rr_reg_if: channel bundle between the producers and the registered N:1 mux.
//   in_data   - CHANNELS packed words, channel k at [k*WIDTH +: WIDTH]
//   in_valid  - per-channel valid flags
//   select    - manual-mode channel index
//   mode      - 0 = manual select, 1 = round-robin
//   out       - registered selected word
//   out_valid - registered valid of the selected channel
//   out_sel   - registered index of the channel that drove out
// master: producer/consumer side; slave: the mux itself.
interface mux_rr_reg_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [SEL_W-1:0]          select;
  logic                      mode;
  logic [WIDTH-1:0]          out;
  logic                      out_valid;
  logic [SEL_W-1:0]          out_sel;

  modport master (
    output in_data, in_valid, select, mode,
    input  out, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, select, mode,
    output out, out_valid, out_sel
  );
endinterface

// File: rtl/mux_rr_reg.sv
// mux_rr_reg: registered CHANNELS:1 multiplexer with manual and round-robin select.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - mux_rr_reg_if slave modport (inputs in_data/in_valid/select/mode,
//           registered outputs out/out_valid/out_sel)
// One selection per clock, one clock of latency, no input-to-output
// combinational path.
module mux_rr_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_rr_reg_if.slave   bus
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] grant;
  logic             grant_found;
  logic [SEL_W-1:0] src;

  // Round-robin search from ptr_q; SEL_W-bit addition wraps the channel index.
  always_comb begin
    idx         = '0;
    grant       = '0;
    grant_found = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = ptr_q + SEL_W'(i);
      if (!grant_found && bus.in_valid[idx]) begin
        grant_found = 1'b1;
        grant       = idx;
      end
    end
  end

  // Manual and granted RR share one data path: in RR the granted channel is
  // valid by construction, so in_valid[src] gives the right flag in both modes.
  always_comb begin
    src         = bus.mode ? grant : bus.select;
    out_d       = out_q;
    out_valid_d = 1'b0;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (!bus.mode || grant_found) begin
      out_d       = bus.in_data[src*WIDTH +: WIDTH];
      out_valid_d = bus.in_valid[src];
      out_sel_d   = src;
      ptr_d       = bus.mode ? SEL_W'(src + 1'b1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux_rr_reg.sv
// tb_mux_rr_reg: directed checks on a WIDTH=8/CHANNELS=4 instance and a
// randomised model comparison on a WIDTH=16/CHANNELS=8 instance.
module tb_mux_rr_reg;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  mux_rr_reg_if #(.WIDTH(8),  .CHANNELS(4)) b4 ();
  mux_rr_reg_if #(.WIDTH(16), .CHANNELS(8)) b8 ();

  mux_rr_reg #(.WIDTH(8),  .CHANNELS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_rr_reg #(.WIDTH(16), .CHANNELS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e_out;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      b4.in_data  = {$urandom, $urandom} & 32'hFFFF_FFFF;
      b4.in_valid = 4'($urandom);
      b4.select   = 2'($urandom);
      b4.mode     = 1'($urandom);
      b8.in_data  = {$urandom, $urandom, $urandom, $urandom};
      b8.in_valid = 8'($urandom);
      b8.select   = 3'($urandom);
      b8.mode     = 1'($urandom);
      tick();
      n_checks++;
      if ({b4.out, b4.out_valid, b4.out_sel} !== 11'd0) begin
        n_fail++;
        $display("FAIL reset4 cycle %0d: got out=%h v=%b sel=%0d, want 0/0/0", c, b4.out, b4.out_valid, b4.out_sel);
      end
      n_checks++;
      if ({b8.out, b8.out_valid, b8.out_sel} !== 20'd0) begin
        n_fail++;
        $display("FAIL reset8 cycle %0d: got out=%h v=%b sel=%0d, want 0/0/0", c, b8.out, b8.out_valid, b8.out_sel);
      end
    end
    rst_n       = 1'b1;
    b4.in_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    b4.in_valid = 4'b0100;
    b4.mode     = 1'b0;
    b4.select   = 2'd2;
    e_out       = 8'hC2;
    tick();
    n_checks++;
    if ({b4.out, b4.out_valid, b4.out_sel} !== {e_out, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL reset_release: got out=%h v=%b sel=%0d, want %h/1/2", b4.out, b4.out_valid, b4.out_sel, e_out);
    end
  endtask

  task automatic test_manual_sweep();
    logic [7:0] e_out;
    logic       e_v;
    b4.in_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    b4.in_valid = 4'b0101;
    b4.mode     = 1'b0;
    for (int s = 0; s < 4; s++) begin
      b4.select = 2'(s);
      e_out     = 8'(8'hA0 + 8'h11 * s);
      e_v       = (s % 2 == 0);
      tick();
      n_checks++;
      if ({b4.out, b4.out_valid, b4.out_sel} !== {e_out, e_v, 2'(s)}) begin
        n_fail++;
        $display("FAIL manual sel=%0d: got out=%h v=%b sel=%0d, want %h/%b/%0d", s, b4.out, b4.out_valid, b4.out_sel, e_out, e_v, s);
      end
    end
  endtask

  task automatic test_rr_full();
    logic [7:0] e_out;
    b4.in_valid = 4'b1111;
    b4.mode     = 1'b1;
    b4.select   = 2'd3;
    for (int c = 0; c < 8; c++) begin
      e_out = 8'(8'hA0 + 8'h11 * (c % 4));
      tick();
      n_checks++;
      if ({b4.out, b4.out_valid, b4.out_sel} !== {e_out, 1'b1, 2'(c % 4)}) begin
        n_fail++;
        $display("FAIL rr_full grant %0d: got out=%h v=%b sel=%0d, want %h/1/%0d", c, b4.out, b4.out_valid, b4.out_sel, e_out, c % 4);
      end
    end
  endtask

  task automatic test_rr_sparse_wrap();
    logic [1:0] e_sel [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
    logic [7:0] e_out;
    b4.in_valid = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      e_out = (e_sel[c] == 2'd0) ? 8'hA0 : 8'hD3;
      tick();
      n_checks++;
      if ({b4.out, b4.out_valid, b4.out_sel} !== {e_out, 1'b1, e_sel[c]}) begin
        n_fail++;
        $display("FAIL rr_sparse %0d: got out=%h v=%b sel=%0d, want %h/1/%0d", c, b4.out, b4.out_valid, b4.out_sel, e_out, e_sel[c]);
      end
    end
    b4.in_valid = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({b4.out, b4.out_valid, b4.out_sel} !== {8'hD3, 1'b0, 2'd3}) begin
        n_fail++;
        $display("FAIL rr_idle_hold %0d: got out=%h v=%b sel=%0d, want d3/0/3", c, b4.out, b4.out_valid, b4.out_sel);
      end
    end
  endtask

  task automatic test_mode_switch_and_reset();
    // {mode, select, rst_n, expected sel, expected valid}
    logic [1:0] e_sel [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0};
    logic       e_v   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       mo    [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       rs    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] e_out;
    b4.in_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      b4.mode   = mo[c];
      b4.select = (c == 3) ? 2'd2 : 2'd0;
      rst_n     = rs[c];
      e_out     = rs[c] ? 8'(8'hA0 + 8'h11 * e_sel[c]) : 8'h00;
      tick();
      n_checks++;
      if ({b4.out, b4.out_valid, b4.out_sel} !== {e_out, e_v[c], e_sel[c]}) begin
        n_fail++;
        $display("FAIL mode_switch step %0d: got out=%h v=%b sel=%0d, want %h/%b/%0d", c, b4.out, b4.out_valid, b4.out_sel, e_out, e_v[c], e_sel[c]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] dat [8];
    logic [7:0]  vld;
    logic [2:0]  sel;
    logic        md;
    logic        rs;
    logic [15:0] m_out = '0;
    logic        m_val = 1'b0;
    int          m_sel = 0;
    int          m_ptr = 0;
    int          g;
    int          cyc_fail = 0;
    // Start from a known state.
    rst_n = 1'b0;
    tick();
    for (int c = 0; c < 1200; c++) begin
      for (int k = 0; k < 8; k++) dat[k] = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       vld = 8'h00;
        1:       vld = 8'hFF;
        default: vld = 8'($urandom) & 8'($urandom);
      endcase
      sel = 3'($urandom_range(0, 7));
      md  = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 29) != 0);
      for (int k = 0; k < 8; k++) b8.in_data[k*16 +: 16] = dat[k];
      b8.in_valid = vld;
      b8.select   = sel;
      b8.mode     = md;
      rst_n       = rs;
      // Reference: reset, manual pick, or first valid channel at/after ptr.
      if (!rs) begin
        m_out = '0; m_val = 1'b0; m_sel = 0; m_ptr = 0;
      end else if (!md) begin
        m_out = dat[sel]; m_val = vld[sel]; m_sel = int'(sel); m_ptr = 0;
      end else begin
        g = -1;
        for (int i = 0; i < 8; i++)
          if (g < 0 && vld[(m_ptr + i) % 8]) g = (m_ptr + i) % 8;
        if (g >= 0) begin
          m_out = dat[g]; m_val = 1'b1; m_sel = g; m_ptr = (g + 1) % 8;
        end else begin
          m_val = 1'b0;
        end
      end
      tick();
      n_checks++;
      if ({b8.out, b8.out_valid, b8.out_sel} !== {m_out, m_val, 3'(m_sel)}) begin
        n_fail++;
        cyc_fail++;
        $display("FAIL random cycle %0d: got out=%h v=%b sel=%0d, want %h/%b/%0d", c, b8.out, b8.out_valid, b8.out_sel, m_out, m_val, m_sel);
      end
    end
    $display("random phase: 1200 cycles, %0d mismatching cycles", cyc_fail);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    b4.in_data = '0; b4.in_valid = '0; b4.select = '0; b4.mode = 1'b0;
    b8.in_data = '0; b8.in_valid = '0; b8.select = '0; b8.mode = 1'b0;
    test_reset();
    test_manual_sweep();
    test_rr_full();
    test_rr_sparse_wrap();
    test_mode_switch_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_rr_reg.md
# mux_rr_reg

Parametrised, registered N:1 channel multiplexer: the next generation of the team's 2:1 select mux. It widens to CHANNELS inputs of WIDTH bits, registers the output, carries a per-channel valid flag, and adds a round-robin auto-select mode alongside manual select. It sits between several producers and a single consumer that samples one registered word per clock.

## Interface
- WIDTH, 8, data bits per channel (>=1)
- CHANNELS, 4, number of input channels (power of two, >=2)
- SEL_W, log2(CHANNELS), derived localparam, not overridable
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low (sampled on rising clk edge)
- in_data  input  CHANNELS*WIDTH  packed channel data; channel k at bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  bit k high = channel k holds valid data
- select  input  SEL_W  channel index used in manual mode
- mode  input  1  0 = manual select, 1 = round-robin
- out  output  WIDTH  registered selected data
- out_valid  output  1  registered valid of the selected channel
- out_sel  output  SEL_W  registered index of the channel that drove out

## Operation
- Internal state: ptr (SEL_W bits), the round-robin search start.
- Reset (rst_n=0 at a rising edge): out=0, out_valid=0, out_sel=0, ptr=0. Reset overrides all other inputs.
- Manual mode (mode=0), every cycle:
  - out <= in_data[select], out_valid <= in_valid[select], out_sel <= select.
  - Data loads even when in_valid[select]=0; out_valid flags it.
  - ptr <= 0.
- Round-robin mode (mode=1), every cycle:
  - Search channels ptr, ptr+1, ..., ptr+CHANNELS-1, all modulo CHANNELS. Grant g = first k with in_valid[k]=1.
  - On a grant: out <= in_data[g], out_valid <= 1, out_sel <= g, ptr <= (g+1) mod CHANNELS. Wrap from CHANNELS-1 to 0 is by natural SEL_W-bit overflow.
  - No valid channel: out and out_sel hold, out_valid <= 0, ptr holds.
  - select is ignored.
- Fairness: if all channels stay continuously valid, grants cycle 0,1,...,CHANNELS-1,0 with no channel granted twice before every other channel is granted once.
- Mode switch 0->1: ptr is already 0 (cleared in manual mode), so the first RR search starts at channel 0.
- Mode switch 1->0: the next cycle behaves as pure manual mode, and ptr clears.
- No X propagation: all outputs are always driven from registers.

## Timing
- Latency: 1 clock from inputs sampled at edge N to outputs visible after edge N. No combinational path from any input to any output.
- All inputs are sampled only at the rising clk edge. Changes between edges have no effect.
- Reset takes effect at the first rising edge with rst_n=0. Outputs are at reset values after that edge. The first functional update occurs at the first edge with rst_n=1.
- Reset asserted mid round-robin sequence: ptr returns to 0, and the sequence restarts at channel 0 after release.
- Throughput: one selection per clock, with no bubbles in either mode.

## Test plan
- Reset: drive random inputs with rst_n=0 for 3 cycles. Expect out=0, out_valid=0, out_sel=0 every cycle. After release, expect the first valid output one edge later.
- Manual sweep (WIDTH=8, CHANNELS=4): in_data={8'hD3,8'hC2,8'hB1,8'hA0}, in_valid=4'b0101, mode=0, select stepping 0..3. Expect out=A0/B1/C2/D3, out_valid=1/0/1/0, out_sel=select, each one cycle after applying it.
- Round-robin full load: in_valid=4'b1111, mode=1 for 8 cycles. Expect out_sel sequence 0,1,2,3,0,1,2,3, with out_valid=1 throughout.
- Round-robin sparse plus wrap: in_valid=4'b1001, mode=1. Expect out_sel 0,3,0,3. Then in_valid=4'b0000: out_valid=0, and out/out_sel hold the last value (3, D3).
- Mode switch and reset mid-operation: in RR with in_valid=4'b1111, after grants 0,1 switch to mode=0 with select=2 for one cycle (expect out_sel=2), then back to mode=1 (expect out_sel=0). Repeat with rst_n pulsed low for one cycle after grant 1 (expect the next grant to be 0).
- Randomised self-check (at least 1000 cycles, CHANNELS=8, WIDTH=16): compare against a behavioural model of ptr and grant. Report pass/fail per cycle and zero mismatches overall.
